// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - pops bytes from a registered-output FIFO and serializes them as UART frames
module uart_tx_fifo_reader #(
    parameter int FETCH_LAT = 2,
    parameter int DATA_BITS = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fifo_empty,
    output logic       fifo_rd_n,
    input  logic [7:0] fifo_data,
    input  logic       baud_tick,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int FCW = $clog2(FETCH_LAT + 1) + 1;
    localparam logic [FCW-1:0] FETCH_LAST = FCW'(FETCH_LAT);
    localparam logic [2:0]     BIT_LAST   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        FETCH,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_nxt;
    logic [FCW-1:0]       fetch_cnt;
    logic [FCW-1:0]       fetch_nxt;
    logic                 par_bit;
    logic                 par_nxt;
    logic                 par_en_q;
    logic                 pen_nxt;
    logic                 txd_nxt;
    logic                 done_nxt;
    logic [1:0]           rst_sync;
    logic                 run;

    // Reset asserts asynchronously but the FSM only starts moving two edges after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            fetch_cnt <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
            txd       <= 1'b1;
            fifo_rd_n <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_idx   <= bit_nxt;
            fetch_cnt <= fetch_nxt;
            par_bit   <= par_nxt;
            par_en_q  <= pen_nxt;
            txd       <= txd_nxt;
            fifo_rd_n <= (state_nxt != POP);
            tx_busy   <= (state_nxt != IDLE);
            tx_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_idx;
        fetch_nxt = fetch_cnt;
        par_nxt   = par_bit;
        pen_nxt   = par_en_q;
        done_nxt  = 1'b0;
        txd_nxt   = 1'b1;

        if (run) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_nxt = POP;
                    end
                end
                POP: begin
                    state_nxt = FETCH;
                    fetch_nxt = FCW'(1);
                end
                FETCH: begin
                    // fifo_data is only trusted FETCH_LAT cycles after the strobe.
                    if (fetch_cnt == FETCH_LAST) begin
                        shreg_nxt = fifo_data[DATA_BITS-1:0];
                        par_nxt   = (^fifo_data[DATA_BITS-1:0]) ^ parity_odd;
                        pen_nxt   = parity_en;
                        state_nxt = ALIGN;
                    end else begin
                        fetch_nxt = fetch_cnt + FCW'(1);
                    end
                end
                ALIGN: begin
                    if (baud_tick) begin
                        state_nxt = START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state_nxt = DATA;
                        bit_nxt   = 3'd0;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shreg_nxt = shreg >> 1;
                        if (bit_idx == BIT_LAST) begin
                            bit_nxt   = 3'd0;
                            state_nxt = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_nxt = bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        done_nxt  = 1'b1;
                        state_nxt = fifo_empty ? IDLE : POP;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // txd is registered from the next state so it never glitches.
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shreg_nxt[0];
            PARITY:  txd_nxt = par_nxt;
            default: txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 Parameter FETCH_LAT, default 2: clock cycles from the FIFO read strobe cycle to the cycle in which fifo_data is sampled.
REQ-002 Parameter DATA_BITS, default 8: serialized data width; legal values 5..8.
REQ-003 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port fifo_empty, input, 1: the FIFO holds no bytes.
REQ-006 Port fifo_rd_n, output, 1: active-low, one-cycle pop strobe to the FIFO.
REQ-007 Port fifo_data, input, 8: FIFO read data, registered inside the FIFO.
REQ-008 Port baud_tick, input, 1: one-cycle pulse per bit period.
REQ-009 Port parity_en, input, 1: adds a parity bit after the data bits.
REQ-010 Port parity_odd, input, 1: 1 selects odd parity, 0 selects even parity.
REQ-011 Port txd, output, 1: serial line output; idle level is 1.
REQ-012 Port tx_busy, output, 1: 1 in every state except IDLE.
REQ-013 Port tx_done, output, 1: one-cycle pulse at the end of each stop bit.

Function
REQ-014 States SHALL be IDLE, POP, FETCH, ALIGN, START, DATA, PARITY and STOP.
REQ-015 IDLE SHALL go to POP on the first cycle in which fifo_empty=0.
REQ-016 POP SHALL last exactly 1 cycle, SHALL drive fifo_rd_n=0, and SHALL then go to FETCH.
REQ-017 fifo_rd_n SHALL be 1 in every state other than POP.
REQ-018 At most one strobe SHALL be issued per character; no pop SHALL be issued while fifo_empty=1.
REQ-019 FETCH SHALL count cycles and, on the cycle exactly FETCH_LAT cycles after the POP cycle, SHALL load fifo_data[DATA_BITS-1:0] into the shift register and go to ALIGN.
REQ-020 At the FETCH-to-ALIGN load, parity SHALL be computed as XOR of the loaded data bits, XORed with parity_odd.
REQ-021 parity_en and parity_odd SHALL be sampled at that load and held for the whole character.
REQ-022 ALIGN SHALL hold txd=1 until baud_tick, then go to START, so that the start bit begins on a tick boundary.
REQ-023 In START, txd SHALL be 0; on baud_tick the state SHALL go to DATA with bit index 0.
REQ-024 In DATA, txd SHALL be the shift register LSB.
REQ-025 In DATA, each baud_tick SHALL shift the register right and increment the bit index.
REQ-026 On the baud_tick with bit index = DATA_BITS-1, DATA SHALL go to PARITY if parity_en=1, else to STOP.
REQ-027 In PARITY, txd SHALL be the computed parity bit; on baud_tick the state SHALL go to STOP.
REQ-028 In STOP, txd SHALL be 1.
REQ-029 On baud_tick in STOP, tx_done SHALL pulse for exactly 1 cycle.
REQ-030 On that same baud_tick, STOP SHALL go to POP if fifo_empty=0 (back-to-back characters), else to IDLE.
REQ-031 baud_tick SHALL be ignored in IDLE, POP and FETCH.
REQ-032 txd SHALL be 1 in IDLE, POP, FETCH and ALIGN.
REQ-033 Each bit SHALL last exactly one baud_tick period.
REQ-034 txd SHALL be driven from a register with no glitches.
REQ-035 The bit counter SHALL be 3 bits wide and SHALL never exceed DATA_BITS-1.
REQ-036 The FETCH counter SHALL NOT wrap before reaching FETCH_LAT.
REQ-037 fifo_empty rising during FETCH or any later state SHALL NOT abort the character in progress.
REQ-038 baud_tick held at 1 continuously SHALL advance one bit per cycle.

Reset
REQ-039 reset_n=0 SHALL immediately force state=IDLE, txd=1, fifo_rd_n=1, tx_busy=0 and tx_done=0, and SHALL clear the shift register, the counters and the parity bit, independent of clock.
REQ-040 Reset asserted mid-character SHALL abandon the character; no stop bit or tx_done SHALL be generated.
REQ-041 Reset release SHALL be synchronous to clock internally; the first state transition SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-042 Single byte: FIFO holds 0xA5, parity_en=0, baud_tick every 16 cycles -> exactly one fifo_rd_n pulse, then txd = 0, 1,0,1,0,0,1,0,1, 1 with each bit 16 cycles, then one tx_done pulse and tx_busy=0.
REQ-043 Parity: byte 0x03 with parity_en=1 -> even parity (parity_odd=0) bit=0; odd parity (parity_odd=1) bit=1; stop bit=1 follows.
REQ-044 Back-to-back: FIFO holds 0x11, 0x22, 0x33 -> exactly 3 pops, no idle gap longer than one bit period between stop and start, and 3 tx_done pulses.
REQ-045 Latency: with FETCH_LAT=2 and FIFO data valid only in cycle POP+2 (garbage before) -> the transmitted byte equals the valid data.
REQ-046 Reset mid-DATA: assert reset_n=0 during bit 4 of 0xFF -> txd=1 within the same cycle, no tx_done; after release the next queued byte transmits intact.
REQ-047 Empty FIFO: fifo_empty=1 for 1000 cycles with baud_tick toggling -> fifo_rd_n stays 1, txd stays 1, tx_busy stays 0.
